// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub
//  Description : Digit-serial two's-complement adder/subtractor, W bits per
//                clock, LSB digit first, with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cIn,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic         c,
    output logic         v
);

    localparam int            C_ND   = N / W;
    localparam int            C_CW   = (C_ND > 1) ? $clog2(C_ND) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_ND - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
            $error("serial_add_sub: N must be >= 2 and a multiple of W, 1 <= W <= N");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [C_CW-1:0] r_cnt;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic [N-1:0]    r_acc;
    logic            r_k;
    logic            r_mode;
    logic            r_xs;
    logic            r_ys;
    logic [N-1:0]    r_z;
    logic            r_c;
    logic            r_v;

    logic            w_accept;
    logic            w_last;
    logic [W:0]      w_dig;
    logic            w_kn;
    logic [N+W-1:0]  w_acc_cat;
    logic [N-1:0]    w_acc_nx;
    logic            w_v;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == C_LAST);

    // One W+1 bit slice: top bit is the carry (add) or the sign, i.e. borrow (sub)
    assign w_dig = r_mode ? ({1'b0, r_x[W-1:0]} - {1'b0, r_y[W-1:0]} - {{W{1'b0}}, r_k})
                          : ({1'b0, r_x[W-1:0]} + {1'b0, r_y[W-1:0]} + {{W{1'b0}}, r_k});
    assign w_kn      = w_dig[W];
    assign w_acc_cat = {w_dig[W-1:0], r_acc};
    assign w_acc_nx  = w_acc_cat[N+W-1:W];

    assign w_v = r_mode ? ((r_xs != r_ys) && (w_acc_nx[N-1] != r_xs))
                        : ((r_xs == r_ys) && (w_acc_nx[N-1] != r_xs));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start  ? S_RUN  : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start  ? S_RUN  : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
            r_k    <= 1'b0;
            r_mode <= 1'b0;
            r_xs   <= 1'b0;
            r_ys   <= 1'b0;
            r_z    <= '0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_x    <= x;
            r_y    <= y;
            r_k    <= cIn;
            r_mode <= mode;
            r_xs   <= x[N-1];
            r_ys   <= y[N-1];
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_x   <= r_x >> W;
            r_y   <= r_y >> W;
            r_k   <= w_kn;
            r_acc <= w_acc_nx;
            // Visible results only move on completion, never mid-operation
            if (w_last) begin
                r_z <= w_acc_nx;
                r_c <= w_kn;
                r_v <= w_v;
            end
        end
    end

    assign z = r_z;
    assign c = r_c;
    assign v = r_v;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_sub
//  Description : Scoreboard bench for serial_add_sub at W=2 plus W=1,4,8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] z;
        logic         c;
        logic         v;
        int           dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[3][$];

    // Bus A drives the W=2 instance
    logic         a_start = 1'b0, a_mode = 1'b0, a_cin = 1'b0;
    logic [N-1:0] a_x = '0, a_y = '0;
    logic         a_busy, a_done, a_c, a_v;
    logic [N-1:0] a_z;

    // Bus B drives the W=1,4,8 instances together
    logic         b_start = 1'b0, b_mode = 1'b0, b_cin = 1'b0;
    logic [N-1:0] b_x = '0, b_y = '0;
    logic [2:0]   b_busy, b_done, b_c, b_v;
    logic [N-1:0] b_z [3];

    serial_add_sub #(.N(N), .W(2)) u_dut (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .x(a_x), .y(a_y),
        .cIn(a_cin), .busy(a_busy), .done(a_done), .z(a_z), .c(a_c), .v(a_v)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic cmp_out(string nm, exp_t e, logic [N-1:0] zz, logic cc, logic vv);
        chk({nm, "_z"}, 32'(zz), 32'(e.z));
        chk({nm, "_c"}, 32'(cc), 32'(e.c));
        chk({nm, "_v"}, 32'(vv), 32'(e.v));
        chk({nm, "_latency"}, cyc, e.dc);
    endtask

    // Reference: whole-word integer arithmetic, overflow from signed range
    function automatic exp_t model(bit m, logic [N-1:0] xx, logic [N-1:0] yy, bit ci, int dc);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(xx);
        uy = int'(yy);
        sx = int'($signed(xx));
        sy = int'($signed(yy));
        if (m) begin
            r    = ux - uy - int'(ci);
            sr   = sx - sy - int'(ci);
            e.c  = (ux < uy + int'(ci));
        end else begin
            r    = ux + uy + int'(ci);
            sr   = sx + sy + int'(ci);
            e.c  = (r >= (1 << N));
        end
        e.z  = r[N-1:0];
        e.v  = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
        e.dc = dc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (a_done) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done W=2 z=%0h", a_z);
            end else begin
                exp_t e;
                e = qa.pop_front();
                cmp_out("W2", e, a_z, a_c, a_v);
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < 3; gk++) begin : g_wsweep
            localparam int WK = (gk == 0) ? 1 : (gk == 1) ? 4 : 8;
            serial_add_sub #(.N(N), .W(WK)) u_dut (
                .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .x(b_x), .y(b_y),
                .cIn(b_cin), .busy(b_busy[gk]), .done(b_done[gk]), .z(b_z[gk]),
                .c(b_c[gk]), .v(b_v[gk])
            );
            always @(negedge clk) begin
                if (b_done[gk]) begin
                    if (qb[gk].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done W=%0d z=%0h", WK, b_z[gk]);
                    end else begin
                        exp_t e;
                        e = qb[gk].pop_front();
                        cmp_out($sformatf("W%0d", WK), e, b_z[gk], b_c[gk], b_v[gk]);
                    end
                end
            end
        end
    endgenerate

    // Called just after a posedge; the following edge accepts
    task automatic issue_a(bit m, logic [N-1:0] xx, logic [N-1:0] yy, bit ci,
                           logic [N-1:0] ez, bit ec, bit ev);
        exp_t e;
        a_mode = m; a_x = xx; a_y = yy; a_cin = ci; a_start = 1'b1;
        e.z = ez; e.c = ec; e.v = ev; e.dc = cyc + 1 + N / 2;
        qa.push_back(e);
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_a();
        for (int i = 0; i < 40 && qa.size() != 0; i++) @(negedge clk);
        if (qa.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_a pending=%0d", qa.size());
            qa.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit           m, ci;
        logic [N-1:0] xx, yy;
        exp_t         e;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_z", 32'(a_z), 0);
        chk("rst_c", 32'(a_c), 0);
        chk("rst_v", 32'(a_v), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue_a(1, 8'h33, 8'h0C, 0, 8'h27, 0, 0); wait_a();
        issue_a(1, 8'h04, 8'h06, 0, 8'hFE, 1, 0); wait_a();
        issue_a(1, 8'h0C, 8'h0A, 1, 8'h01, 0, 0); wait_a();
        issue_a(1, 8'h7F, 8'h80, 0, 8'hFF, 1, 1); wait_a();
        issue_a(1, 8'h55, 8'h55, 0, 8'h00, 0, 0); wait_a();
        issue_a(0, 8'h64, 8'h32, 0, 8'h96, 0, 1); wait_a();
        issue_a(0, 8'hC8, 8'h64, 0, 8'h2C, 1, 0); wait_a();

        // start pulses and operand changes while busy are ignored
        issue_a(0, 8'h10, 8'h20, 1, 8'h31, 0, 0);
        a_start = 1'b1; a_x = 8'hAA; a_y = 8'h55; a_mode = 1'b1; a_cin = 1'b0;
        @(negedge clk);
        chk("busy_in_run", 32'(a_busy), 1);
        chk("z_stable_run", 32'(a_z), 32'h2C);
        chk("c_stable_run", 32'(a_c), 1);
        @(posedge clk); #1;
        a_x = 8'hF0;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_a();

        // Back-to-back: start held, next op presented on each done
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                for (int i = 0; i < 20 && !a_done; i++) @(negedge clk);
                if (!a_done) begin
                    checks++;
                    failures++;
                    $display("FAIL b2b_timeout op=%0d", j);
                end
            end
            m = 1'($urandom); ci = 1'($urandom); xx = N'($urandom); yy = N'($urandom);
            a_mode = m; a_x = xx; a_y = yy; a_cin = ci; a_start = 1'b1;
            qa.push_back(model(m, xx, yy, ci, cyc + 1 + N / 2));
            @(negedge clk);
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_a();

        // Reset during RUN aborts with no done
        a_mode = 1'b0; a_x = 8'h7F; a_y = 8'h01; a_cin = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_done", 32'(a_done), 0);
        chk("midrst_z", 32'(a_z), 0);
        chk("midrst_c", 32'(a_c), 0);
        chk("midrst_v", 32'(a_v), 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        issue_a(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1); wait_a();

        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom); ci = 1'($urandom); xx = N'($urandom); yy = N'($urandom);
            e = model(m, xx, yy, ci, 0);
            issue_a(m, xx, yy, ci, e.z, e.c, e.v);
            wait_a();
        end

        // Width sweep on W=1,4,8 (W=8 is the single-cycle case)
        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom); ci = 1'($urandom);
            xx = (i % 5 == 0) ? 8'h80 : N'($urandom);
            yy = (i % 7 == 0) ? 8'h7F : N'($urandom);
            b_mode = m; b_x = xx; b_y = yy; b_cin = ci; b_start = 1'b1;
            qb[0].push_back(model(m, xx, yy, ci, cyc + 1 + N / 1));
            qb[1].push_back(model(m, xx, yy, ci, cyc + 1 + N / 4));
            qb[2].push_back(model(m, xx, yy, ci, cyc + 1 + N / 8));
            @(posedge clk); #1;
            b_start = 1'b0;
            for (int t = 0; t < 40 && (qb[0].size() + qb[1].size() + qb[2].size()) != 0; t++)
                @(negedge clk);
            if ((qb[0].size() + qb[1].size() + qb[2].size()) != 0) begin
                checks++;
                failures++;
                $display("FAIL timeout_b op=%0d", i);
                qb[0].delete(); qb[1].delete(); qb[2].delete();
            end
            @(posedge clk); #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb[0].size() + qb[1].size() + qb[2].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
